// File: rtl/sigdelay_echo_if.sv
// sigdelay_echo_if: sample-stream bundle between a sample source and the
// delay/echo block. The source drives the master side, the block is the slave.
interface sigdelay_echo_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     en;
  logic [ADDRESS_WIDTH-1:0] delay;
  logic [DATA_WIDTH-1:0]    din;
  logic [DATA_WIDTH-1:0]    dout;
  logic                     dout_valid;
  logic                     primed;

  modport master (
    output en, delay, din,
    input  dout, dout_valid, primed
  );

  modport slave (
    input  en, delay, din,
    output dout, dout_valid, primed
  );
endinterface

// File: rtl/sigdelay_echo.sv
// sigdelay_echo: circular-buffer sample delay line with a fill/prime state
// machine that masks stale RAM contents until `delay` samples have been
// buffered since reset or the last delay change.
// Optional feature macro: ECHO_FEEDBACK_EN. When defined, each written sample
// is sat(din + (echo >>> FB_SHIFT)), with the write pipelined one cycle and
// read-after-pending-write forwarding for delay=1.
module sigdelay_echo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int FB_SHIFT      = 1
) (
  input  logic           clk,
  input  logic           rst,
  sigdelay_echo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDRESS_WIDTH-1:0] delay_q, delay_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q;
  logic [DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                     dout_valid_q;
  logic                     primed_q;
  logic                     real_s;
  logic                     bypass_s;
  logic [ADDRESS_WIDTH-1:0] rd_addr_s;
  logic [DATA_WIDTH-1:0]    rd_data_s;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  // Fill/prime FSM: decides whether this accepted sample carries real data
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    delay_d    = delay_q;
    real_s     = 1'b0;
    if (bus.en) begin
      if (bus.delay != delay_q) begin
        // New delay: older buffer contents no longer line up, start over
        delay_d    = bus.delay;
        fill_cnt_d = {ADDRESS_WIDTH{1'b0}};
        state_d    = S_FILL;
        real_s     = 1'b0;
      end else begin
        case (state_q)
          S_FILL: begin
            // fill_cnt+1 samples have been written since the delay was set
            if (({1'b0, fill_cnt_q} + (ADDRESS_WIDTH + 1)'(1)) >= {1'b0, delay_q}) begin
              state_d = S_RUN;
              real_s  = 1'b1;
            end else begin
              fill_cnt_d = fill_cnt_q + ADDRESS_WIDTH'(1);
              real_s     = 1'b0;
            end
          end
          S_RUN: begin
            real_s = 1'b1;
          end
          default: begin
            state_d    = S_FILL;
            fill_cnt_d = {ADDRESS_WIDTH{1'b0}};
            real_s     = 1'b0;
          end
        endcase
      end
    end else begin
      real_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FILL;
      fill_cnt_q <= {ADDRESS_WIDTH{1'b0}};
      delay_q    <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      delay_q    <= delay_d;
    end
  end

  // Read address and output select; delay=0 bypasses the RAM entirely
  always_comb begin
    rd_addr_s = wr_ptr_q - bus.delay;
    bypass_s  = (bus.delay == {ADDRESS_WIDTH{1'b0}});
    if (!real_s) begin
      dout_d = {DATA_WIDTH{1'b0}};
    end else if (bypass_s) begin
      dout_d = bus.din;
    end else begin
      dout_d = rd_data_s;
    end
  end

  // Write pointer and registered output stage (doubles as the RAM read register)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= {ADDRESS_WIDTH{1'b0}};
      dout_q       <= {DATA_WIDTH{1'b0}};
      dout_valid_q <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      dout_valid_q <= bus.en;
      if (bus.en) begin
        wr_ptr_q <= wr_ptr_q + ADDRESS_WIDTH'(1);
        dout_q   <= dout_d;
        primed_q <= real_s;
      end
    end
  end

`ifdef ECHO_FEEDBACK_EN
  logic                     pend_valid_q;
  logic [ADDRESS_WIDTH-1:0] pend_addr_q;
  logic [DATA_WIDTH-1:0]    pend_din_q;
  logic                     pend_fb_q;
  logic [DATA_WIDTH-1:0]    fb_term_s;
  logic [DATA_WIDTH-1:0]    pend_wdata_s;

  // Signed add clamped to the DATA_WIDTH two's-complement range
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sat_add = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      sat_add = sum[DATA_WIDTH-1:0];
    end
  endfunction

  // Pending write value (echo is the previous sample's dout) and read forwarding
  always_comb begin
    fb_term_s = $signed(dout_q) >>> FB_SHIFT;
    if (pend_fb_q) begin
      pend_wdata_s = sat_add(pend_din_q, fb_term_s);
    end else begin
      pend_wdata_s = pend_din_q;
    end
    if (pend_valid_q && (pend_addr_q == rd_addr_s)) begin
      rd_data_s = pend_wdata_s;
    end else begin
      rd_data_s = mem[rd_addr_s];
    end
  end

  // Pending-write register: captures the sample until its echo is known
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= {ADDRESS_WIDTH{1'b0}};
      pend_din_q   <= {DATA_WIDTH{1'b0}};
      pend_fb_q    <= 1'b0;
    end else begin
      pend_valid_q <= bus.en;
      if (bus.en) begin
        pend_addr_q <= wr_ptr_q;
        pend_din_q  <= bus.din;
        pend_fb_q   <= !bypass_s;
      end
    end
  end

  // RAM write port, one cycle behind the accepted sample
  always_ff @(posedge clk) begin
    if (!rst && pend_valid_q) begin
      mem[pend_addr_q] <= pend_wdata_s;
    end
  end
`else
  logic unused_fb_shift_s;
  assign unused_fb_shift_s = (FB_SHIFT != 0);

  // Plain RAM read port
  always_comb begin
    rd_data_s = mem[rd_addr_s];
  end

  // RAM write port: din stored unmodified on each accepted sample
  always_ff @(posedge clk) begin
    if (!rst && bus.en) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end
`endif

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.primed     = primed_q;
endmodule

// File: tb/tb_sigdelay_echo.sv
// tb_sigdelay_echo: directed vector table for the 256-deep instance plus
// hand-written sequences for wrap-around (16-deep instance) and echo feedback.
module tb_sigdelay_echo;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sigdelay_echo_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8)) b8 ();
  sigdelay_echo_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) b4 ();

  sigdelay_echo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(8), .FB_SHIFT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  sigdelay_echo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .FB_SHIFT(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  typedef struct {
    string      tag;
    logic       rst;
    logic       en;
    logic [7:0] delay;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       exp_primed;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string tag, input logic r, input logic e, input logic [7:0] d,
                     input logic [7:0] x, input logic [7:0] ed, input logic ev, input logic ep);
    vec_t v;
    v.tag = tag; v.rst = r; v.en = e; v.delay = d; v.din = x;
    v.exp_dout = ed; v.exp_valid = ev; v.exp_primed = ep;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle on the 256-deep instance, then compare its outputs
  task automatic step8(input string tag, input logic [7:0] d, input logic [7:0] x,
                       input logic [7:0] ed, input logic ep);
    b8.en = 1'b1; b8.delay = d; b8.din = x;
    @(posedge clk); #1;
    check({tag, " dout"}, b8.dout, ed);
    check({tag, " valid"}, {7'd0, b8.dout_valid}, 8'd1);
    check({tag, " primed"}, {7'd0, b8.primed}, {7'd0, ep});
  endtask

  function automatic logic [7:0] sat8(input int v);
    if (v > 127) return 8'd127;
    else if (v < -128) return 8'h80;
    else return v[7:0];
  endfunction

  initial begin
    logic [7:0] wv [40];
    logic [7:0] ev [40];
    logic [7:0] seq [9];
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    b8.en = 1'b0; b8.delay = 8'd0; b8.din = 8'd0;
    b4.en = 1'b0; b4.delay = 4'd0; b4.din = 8'd0;

    // Reset state
    add("reset", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    // delay=4, din=1..8: four masked outputs then the stream 4 samples late
    add("d4_1", 1'b0, 1'b1, 8'd4, 8'd1, 8'd0, 1'b1, 1'b0);
    add("d4_2", 1'b0, 1'b1, 8'd4, 8'd2, 8'd0, 1'b1, 1'b0);
    add("d4_3", 1'b0, 1'b1, 8'd4, 8'd3, 8'd0, 1'b1, 1'b0);
    add("d4_4", 1'b0, 1'b1, 8'd4, 8'd4, 8'd0, 1'b1, 1'b0);
    add("d4_5", 1'b0, 1'b1, 8'd4, 8'd5, 8'd1, 1'b1, 1'b1);
    add("d4_6", 1'b0, 1'b1, 8'd4, 8'd6, 8'd2, 1'b1, 1'b1);
    add("d4_7", 1'b0, 1'b1, 8'd4, 8'd7, 8'd3, 1'b1, 1'b1);
    add("d4_8", 1'b0, 1'b1, 8'd4, 8'd8, 8'd4, 1'b1, 1'b1);
    // Runtime change 4 -> 2: two masked outputs, then din from 2 samples earlier
    add("d2_9",  1'b0, 1'b1, 8'd2, 8'd9,  8'd0,  1'b1, 1'b0);
    add("d2_10", 1'b0, 1'b1, 8'd2, 8'd10, 8'd0,  1'b1, 1'b0);
    add("d2_11", 1'b0, 1'b1, 8'd2, 8'd11, 8'd9,  1'b1, 1'b1);
    add("d2_12", 1'b0, 1'b1, 8'd2, 8'd12, 8'd10, 1'b1, 1'b1);
    // Reset mid-stream with en high clears everything next cycle
    add("rst_mid", 1'b1, 1'b1, 8'd2, 8'd13, 8'd0, 1'b0, 1'b0);
    // delay=0 bypass right after reset, then an idle cycle holds dout
    add("byp",      1'b0, 1'b1, 8'd0, 8'h5A, 8'h5A, 1'b1, 1'b1);
    add("byp_idle", 1'b0, 1'b0, 8'd0, 8'h11, 8'h5A, 1'b0, 1'b1);
    // delay=3 with en toggling; idle cycles carry junk din/delay that must be ignored
    add("tg_rst", 1'b1, 1'b0, 8'd0, 8'd0,  8'd0,  1'b0, 1'b0);
    add("tg_10",  1'b0, 1'b1, 8'd3, 8'd10, 8'd0,  1'b1, 1'b0);
    add("tg_i1",  1'b0, 1'b0, 8'd7, 8'd99, 8'd0,  1'b0, 1'b0);
    add("tg_20",  1'b0, 1'b1, 8'd3, 8'd20, 8'd0,  1'b1, 1'b0);
    add("tg_i2",  1'b0, 1'b0, 8'd7, 8'd99, 8'd0,  1'b0, 1'b0);
    add("tg_30",  1'b0, 1'b1, 8'd3, 8'd30, 8'd0,  1'b1, 1'b0);
    add("tg_i3",  1'b0, 1'b0, 8'd7, 8'd99, 8'd0,  1'b0, 1'b0);
    add("tg_40",  1'b0, 1'b1, 8'd3, 8'd40, 8'd10, 1'b1, 1'b1);
    add("tg_i4",  1'b0, 1'b0, 8'd7, 8'd99, 8'd10, 1'b0, 1'b1);
    add("tg_50",  1'b0, 1'b1, 8'd3, 8'd50, 8'd20, 1'b1, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      b8.en   = vecs[i].en;
      b8.delay = vecs[i].delay;
      b8.din  = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("%s dout", vecs[i].tag), b8.dout, vecs[i].exp_dout);
      check($sformatf("%s valid", vecs[i].tag), {7'd0, b8.dout_valid}, {7'd0, vecs[i].exp_valid});
      check($sformatf("%s primed", vecs[i].tag), {7'd0, b8.primed}, {7'd0, vecs[i].exp_primed});
    end

    // Wrap on the 16-deep instance: delay=15, din=n for 40 samples
    rst = 1'b1; b8.en = 1'b0; b4.en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      ev[n] = (n >= 15) ? wv[n-15] : 8'd0;
`ifdef ECHO_FEEDBACK_EN
      wv[n] = sat8(n + ($signed(ev[n]) >>> 1));
`else
      wv[n] = n[7:0];
`endif
      b4.en = 1'b1; b4.delay = 4'd15; b4.din = n[7:0];
      @(posedge clk); #1;
      check($sformatf("wrap[%0d] dout", n), b4.dout, ev[n]);
      check($sformatf("wrap[%0d] primed", n), {7'd0, b4.primed}, (n >= 15) ? 8'd1 : 8'd0);
    end
    b4.en = 1'b0;

    // delay=1 impulse response
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef ECHO_FEEDBACK_EN
    seq = '{8'd0, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1, 8'd0};
`else
    seq = '{8'd0, 8'd64, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
    for (int k = 0; k < 9; k++) begin
      step8($sformatf("imp[%0d]", k), 8'd1, (k == 0) ? 8'd64 : 8'd0, seq[k], (k != 0));
    end

    // Full-scale inputs with delay=1: feedback must clamp at +127
    rst = 1'b1; b8.en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step8("sat0", 8'd1, 8'd127, 8'd0,   1'b0);
    step8("sat1", 8'd1, 8'd127, 8'd127, 1'b1);
    step8("sat2", 8'd1, 8'd127, 8'd127, 1'b1);
    step8("sat3", 8'd1, 8'd0,   8'd127, 1'b1);
`ifdef ECHO_FEEDBACK_EN
    step8("sat4", 8'd1, 8'd0,   8'd63,  1'b1);
`else
    step8("sat4", 8'd1, 8'd0,   8'd0,   1'b1);
`endif
    b8.en = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sigdelay_echo.md
Name: sigdelay_echo

Overview:
- Parametrised successor to the single-offset signal delay block.
- Circular-buffer delay line with a per-sample strobe, registered output with valid, and a fill/prime state machine that masks stale RAM until enough samples exist.
- Delay can be reprogrammed at run time.
- Optional echo feedback path for the audio-effect chain: mic/ROM source -> this block -> output/plot stage.

Parameters:
- DATA_WIDTH, 8: sample width. Two's-complement where arithmetic is applied.
- ADDRESS_WIDTH, 8: buffer address width. DEPTH = 2**ADDRESS_WIDTH samples.
- FB_SHIFT, 1: feedback attenuation, arithmetic right shift of the echoed sample (used only with ECHO_FEEDBACK_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  sample strobe; one sample accepted per cycle with en=1
- delay  input  ADDRESS_WIDTH  delay in samples, 0..DEPTH-1; sampled on en cycles
- din  input  DATA_WIDTH  input sample
- dout  output  DATA_WIDTH  delayed (or echoed) sample, registered
- dout_valid  output  1  pulses 1 cycle after each accepted sample
- primed  output  1  high when dout carries real buffered data (state RUN)

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=0, fill_cnt=0, delay_q=0, state=FILL, dout=0, dout_valid=0, primed=0. RAM contents are not cleared; stale data is masked by FILL.
- Storage: simple dual-port RAM, DEPTH x DATA_WIDTH, synchronous write and synchronous read, read latency 1.
- Accepted sample (en=1):
  - Write din (or the feedback value) at wr_ptr.
  - Read address = (wr_ptr - delay) mod DEPTH, ADDRESS_WIDTH-bit wrap.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
- Latency: dout/dout_valid update exactly 1 cycle after the en cycle.
- en=0: no write, no pointer move; dout holds its value; dout_valid=0 next cycle.
- delay=0: bypass. dout = din of the same accepted sample, 1 cycle later. No RAM read/write hazard; write-first is not relied on, a mux is used.
- State machine (updated on en cycles only):
  - FILL: dout=0 for each accepted sample; fill_cnt increments. When fill_cnt+1 >= delay, go to RUN. delay=0 goes to RUN on the first sample.
  - RUN: dout = RAM read data, i.e. the sample accepted exactly `delay` accepted-samples earlier. primed=1.
  - Delay change: on any en cycle where delay != delay_q, set delay_q <= delay, fill_cnt <= 0, state <= FILL, primed drops. That sample's output is masked (0). wr_ptr is not reset.
- Reset mid-operation: everything returns to reset values within the cycle; any in-flight read is discarded (dout_valid=0).
- Back-to-back en on every cycle is supported at full rate.

Optional Feature:
- Macro: ECHO_FEEDBACK_EN.
- Defined:
  - Value written = sat(din + (echo >>> FB_SHIFT)), signed. echo = masked delayed sample (0 in FILL); saturate to DATA_WIDTH signed min/max.
  - Because echo arrives 1 cycle late, the write is pipelined one cycle (pending data/address register).
  - A read hitting the pending write address (delay=1, consecutive en) is forwarded from the pending register.
  - delay=0 disables feedback (writes din).
  - dout = RAM/forwarded value, i.e. the echo.
- Undefined: plain delay line; din written unmodified; no pending-write stage or forwarding logic.

Test Plan:
- Reset then delay=4, en=1 every cycle, din=1,2,3,...: dout_valid every cycle from cycle 1; dout=0,0,0,0 (primed=0), then 1,2,3... with primed=1 from the 5th output.
- delay=0, din=0x5A: dout=0x5A one cycle later, primed=1 immediately, dout_valid=1.
- delay=3, en toggling 1,0,1,0 with din=10,20,30,40,50: delay counts accepted samples only; outputs are 0,0,0,10,20; dout holds on en=0 cycles with dout_valid=0.
- Wrap: ADDRESS_WIDTH=4, delay=15, stream 40 samples of din=n: dout = n-15 for n>=15, correct across the wr_ptr 15->0 wrap.
- Runtime delay change 4->2 mid-stream: the next 2 outputs are 0 with primed=0, then dout = din from 2 samples earlier; rst asserted mid-stream clears dout, dout_valid and primed the next cycle.
- ECHO_FEEDBACK_EN, FB_SHIFT=1, delay=1, single impulse din=64 then zeros, en every cycle: dout sequence 0,64,32,16,8,4,2,1,0 (forwarding path). Impulse din=127 followed by din=127: writes saturate at 127.
